// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: time-sliced digit select with
// dead-time between digits and frame-aligned double-buffered display data.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DEAD   = 2'd2
  } state_t;

  // Active-low a..g pattern for one hex nibble; bit 7 (dp) is merged by the caller.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat[6:0];
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       shd_din_q, shd_din_d;
  logic [3:0]        shd_dp_q, shd_dp_d;
  logic [3:0]        shd_blank_q, shd_blank_d;
  logic [15:0]       pnd_din_q, pnd_din_d;
  logic [3:0]        pnd_dp_q, pnd_dp_d;
  logic [3:0]        pnd_blank_q, pnd_blank_d;
  logic              pend_valid_q, pend_valid_d;
  logic [3:0]        sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;
  logic              wrap;

  // Scan sequencing: digit lit for SCAN_DIV cycles, then DEAD_CYC cycles dark.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = ACTIVE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (DEAD_CYC > 0) begin
            state_d = DEAD;
          end else begin
            idx_d = idx_q + 2'd1;
            wrap  = (idx_q == 2'd3);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          wrap    = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
      wrap    = 1'b0;
    end
  end

  // Double buffer: while scanning, loads park in pending until the frame wraps.
  always_comb begin
    shd_din_d    = shd_din_q;
    shd_dp_d     = shd_dp_q;
    shd_blank_d  = shd_blank_q;
    pnd_din_d    = pnd_din_q;
    pnd_dp_d     = pnd_dp_q;
    pnd_blank_d  = pnd_blank_q;
    pend_valid_d = pend_valid_q;
    if (state_q == IDLE) begin
      if (load) begin
        shd_din_d   = din;
        shd_dp_d    = dp;
        shd_blank_d = blank;
      end
    end else if (wrap) begin
      // A load coinciding with the wrap is newer than anything pending.
      if (load) begin
        shd_din_d   = din;
        shd_dp_d    = dp;
        shd_blank_d = blank;
      end else if (pend_valid_q) begin
        shd_din_d   = pnd_din_q;
        shd_dp_d    = pnd_dp_q;
        shd_blank_d = pnd_blank_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pnd_din_d    = din;
      pnd_dp_d     = dp;
      pnd_blank_d  = blank;
      pend_valid_d = 1'b1;
    end
  end

  // Outputs are derived from next-state values so they register on the same edge.
  always_comb begin
    sel_d        = 4'hF;
    seg_d        = 8'hFF;
    frame_done_d = wrap;
    if (state_d == ACTIVE) begin
      sel_d[idx_d] = 1'b0;
      if (!shd_blank_d[idx_d]) begin
        seg_d = {~shd_dp_d[idx_d], hex_to_seg(shd_din_d[{idx_d, 2'b00} +: 4])};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      shd_din_q    <= 16'h0000;
      shd_dp_q     <= 4'h0;
      shd_blank_q  <= 4'h0;
      pnd_din_q    <= 16'h0000;
      pnd_dp_q     <= 4'h0;
      pnd_blank_q  <= 4'h0;
      pend_valid_q <= 1'b0;
      sel_q        <= 4'hF;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shd_din_q    <= shd_din_d;
      shd_dp_q     <= shd_dp_d;
      shd_blank_q  <= shd_blank_d;
      pnd_din_q    <= pnd_din_d;
      pnd_dp_q     <= pnd_dp_d;
      pnd_blank_q  <= pnd_blank_d;
      pend_valid_q <= pend_valid_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without dead-time) driven by shared
// stimulus and compared every cycle against a time-slot reference model.
module tb_seg_scan_ctrl;

  localparam int SD = 8;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  sel0, sel1;
  logic [7:0]  seg0, seg1;
  logic        fd0, fd1;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .dp(dp), .blank(blank),
    .sel(sel0), .seg(seg0), .frame_done(fd0)
  );

  seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din), .dp(dp), .blank(blank),
    .sel(sel1), .seg(seg1), .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: each instance is either off, or t cycles into its frame.
  int          m_period [2] = '{SD + 2, SD};
  bit          m_on     [2];
  int          m_t      [2];
  logic [15:0] m_sdin   [2];
  logic [3:0]  m_sdp    [2];
  logic [3:0]  m_sblk   [2];
  logic [15:0] m_pdin   [2];
  logic [3:0]  m_pdp    [2];
  logic [3:0]  m_pblk   [2];
  bit          m_pv     [2];
  logic [3:0]  e_sel    [2];
  logic [7:0]  e_seg    [2];
  logic        e_fd     [2];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int  p;
    bit  was;
    bit  wrap;
    int  d;
    logic [3:0] nib;
    p = m_period[k];
    e_fd[k] = 1'b0;
    if (rst) begin
      m_on[k] = 0; m_t[k] = 0; m_pv[k] = 0;
      m_sdin[k] = '0; m_sdp[k] = '0; m_sblk[k] = '0;
      m_pdin[k] = '0; m_pdp[k] = '0; m_pblk[k] = '0;
    end else begin
      was  = m_on[k];
      wrap = was && en && (((m_t[k] + 1) % (4 * p)) == 0);
      if (!was) begin
        if (load) begin m_sdin[k] = din; m_sdp[k] = dp; m_sblk[k] = blank; end
      end else if (wrap) begin
        if (load) begin
          m_sdin[k] = din; m_sdp[k] = dp; m_sblk[k] = blank;
        end else if (m_pv[k]) begin
          m_sdin[k] = m_pdin[k]; m_sdp[k] = m_pdp[k]; m_sblk[k] = m_pblk[k];
        end
        m_pv[k] = 0;
      end else if (load) begin
        m_pdin[k] = din; m_pdp[k] = dp; m_pblk[k] = blank; m_pv[k] = 1;
      end
      if (!en) begin
        m_on[k] = 0; m_t[k] = 0;
      end else if (!was) begin
        m_on[k] = 1; m_t[k] = 0;
      end else begin
        m_t[k] = (m_t[k] + 1) % (4 * p);
      end
      e_fd[k] = wrap;
    end
    e_sel[k] = 4'hF;
    e_seg[k] = 8'hFF;
    if (m_on[k] && (m_t[k] % p) < SD) begin
      d = (m_t[k] / p) % 4;
      e_sel[k] = ~(4'b0001 << d);
      nib = 4'((m_sdin[k] >> (4 * d)) & 16'hF);
      if (!m_sblk[k][d]) e_seg[k] = {~m_sdp[k][d], hex_tbl[nib][6:0]};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("sel_dead", {12'h0, sel0}, {12'h0, e_sel[0]});
    check("seg_dead", {8'h0, seg0},  {8'h0, e_seg[0]});
    check("fd_dead",  {15'h0, fd0},  {15'h0, e_fd[0]});
    check("sel_nodead", {12'h0, sel1}, {12'h0, e_sel[1]});
    check("seg_nodead", {8'h0, seg1},  {8'h0, e_seg[1]});
    check("fd_nodead",  {15'h0, fd1},  {15'h0, e_fd[1]});
  endtask

  task automatic wait_t(input int k, input int target);
    for (int i = 0; i < 200 && !(m_on[k] && m_t[k] == target); i++) tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; din = '0; dp = '0; blank = '0;
    repeat (3) tick();
    check("rst_sel", {12'h0, sel0}, 16'h000F);
    check("rst_seg", {8'h0, seg0},  16'h00FF);
    check("rst_fd",  {15'h0, fd0},  16'h0000);

    // Load in IDLE, then scan 1234
    rst = 1'b0; en = 1'b0;
    tick();
    load = 1'b1; din = 16'h1234;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check("first_sel", {12'h0, sel0}, 16'h000E);
    check("first_seg", {8'h0, seg0},  16'h0099);

    // Mid-frame load only shows after the wrap
    wait_t(0, 12);
    load = 1'b1; din = 16'hABCD;
    tick();
    load = 1'b0;
    wait_t(0, 39);
    tick();
    check("wrap_fd",  {15'h0, fd0}, 16'h0001);
    check("wrap_seg", {8'h0, seg0}, 16'h00A1);

    // Load exactly on the wrap edge goes straight to the display
    wait_t(0, 39);
    load = 1'b1; din = 16'h0000; dp = 4'h1;
    tick();
    load = 1'b0; dp = 4'h0;
    check("wrapload_seg", {8'h0, seg0}, 16'h0040);
    check("wrapload_pv", {15'h0, dut0.pend_valid_q}, 16'h0000);

    // Disable during digit 2, re-enable restarts at digit 0
    wait_t(0, 22);
    en = 1'b0;
    tick();
    check("off_sel", {12'h0, sel0}, 16'h000F);
    check("off_seg", {8'h0, seg0},  16'h00FF);
    en = 1'b1;
    tick();
    check("restart_sel", {12'h0, sel0}, 16'h000E);

    // Reset mid-frame discards a pending load
    wait_t(0, 15);
    load = 1'b1; din = 16'h8888;
    tick();
    load = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_sel", {12'h0, sel0}, 16'h000F);
    rst = 1'b0;
    tick();
    check("afterrst_seg", {8'h0, seg0}, 16'h00C0);
    repeat (45) tick();
    check("afterrst_seg2", {8'h0, seg0}, {8'h0, e_seg[0]});

    // Blanked digit on the no-dead-time instance
    en = 1'b0;
    tick();
    load = 1'b1; din = 16'h5678; blank = 4'h2;
    tick();
    load = 1'b0; blank = 4'h0; en = 1'b1;
    wait_t(1, 8);
    check("blank_sel", {12'h0, sel1}, 16'h000D);
    check("blank_seg", {8'h0, seg1},  16'h00FF);
    tick();
    check("blank_nogap", {12'h0, sel1}, 16'h000D);
    repeat (40) tick();

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 99) < 96);
      load  = ($urandom_range(0, 9) == 0);
      din   = 16'($urandom);
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
